// File: rtl/gfx_rom_arbiter.sv
// -----------------------------------------------------------------------------
// gfx_rom_arbiter
//
// Shares a single graphics ROM read port between the tile (char) fetcher and
// the sprite line-buffer fetcher. One access is in flight at a time. Char has
// fixed priority, but a streak counter hands the port to the sprite fetcher
// after STARVE consecutive contested char grants, so sprites always progress.
//
// Parameters
//   AW       ROM address width
//   DW       ROM data width, {plane2[7:0], plane1[7:0]}
//   ROM_LAT  ROM read latency in cycles (1..7)
//   STARVE   contested char grants before sprite is forced through (1..15)
//
// Ports
//   clk_sys            system clock, rising edge
//   reset_n            asynchronous active-low reset
//   chr_req/chr_addr   char request level and address (held until chr_ack)
//   chr_ack/chr_data   one-cycle ack pulse, registered read data (held)
//   spr_req/spr_addr   sprite request level and address (held until spr_ack)
//   spr_ack/spr_data   one-cycle ack pulse, registered read data (held)
//   rom_addr/rom_rd    registered ROM address and one-cycle read strobe
//   rom_data           ROM read data
//   busy               high whenever the arbiter is not idle
// -----------------------------------------------------------------------------
module gfx_rom_arbiter #(
  parameter int AW      = 12,
  parameter int DW      = 16,
  parameter int ROM_LAT = 2,
  parameter int STARVE  = 3
) (
  input  logic          clk_sys,
  input  logic          reset_n,
  input  logic          chr_req,
  input  logic [AW-1:0] chr_addr,
  output logic          chr_ack,
  output logic [DW-1:0] chr_data,
  input  logic          spr_req,
  input  logic [AW-1:0] spr_addr,
  output logic          spr_ack,
  output logic [DW-1:0] spr_data,
  output logic [AW-1:0] rom_addr,
  output logic          rom_rd,
  input  logic [DW-1:0] rom_data,
  output logic          busy
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // The countdown covers the strobe cycle itself plus ROM_LAT cycles, so the
  // data edge lands ROM_LAT+1 edges after the grant edge.
  localparam logic [2:0] LAT_LOAD   = 3'(ROM_LAT);
  localparam logic [3:0] STARVE_MAX = 4'(STARVE);

  localparam logic GRANT_CHR = 1'b0;
  localparam logic GRANT_SPR = 1'b1;

  state_t        state_r;
  logic [3:0]    streak_r;
  logic          grant_r;
  logic [2:0]    lat_cnt_r;

  logic          any_req_s;
  logic          pick_spr_s;
  logic [3:0]    next_streak_s;
  logic [AW-1:0] win_addr_s;

  // Winner selection and streak update for a grant taken in IDLE.
  always_comb begin
    any_req_s     = chr_req | spr_req;
    pick_spr_s    = GRANT_CHR;
    next_streak_s = 4'd0;
    if (chr_req && spr_req) begin
      // Contested: char wins until the streak reaches the starvation limit.
      // The >= keeps the counter bounded even if it were ever corrupted.
      if (streak_r >= STARVE_MAX) begin
        pick_spr_s    = GRANT_SPR;
        next_streak_s = 4'd0;
      end else begin
        pick_spr_s    = GRANT_CHR;
        next_streak_s = streak_r + 4'd1;
      end
    end else if (spr_req) begin
      pick_spr_s    = GRANT_SPR;
      next_streak_s = 4'd0;
    end else begin
      // Char alone (or nobody): an uncontested grant clears the streak.
      pick_spr_s    = GRANT_CHR;
      next_streak_s = 4'd0;
    end
    if (pick_spr_s == GRANT_SPR) begin
      win_addr_s = spr_addr;
    end else begin
      win_addr_s = chr_addr;
    end
  end

  // Access sequencer: grant, ROM strobe, latency countdown, capture and ack.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state_r   <= ST_IDLE;
      streak_r  <= 4'd0;
      grant_r   <= GRANT_CHR;
      lat_cnt_r <= 3'd0;
      rom_addr  <= {AW{1'b0}};
      rom_rd    <= 1'b0;
      chr_ack   <= 1'b0;
      spr_ack   <= 1'b0;
      chr_data  <= {DW{1'b0}};
      spr_data  <= {DW{1'b0}};
      busy      <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          chr_ack <= 1'b0;
          spr_ack <= 1'b0;
          if (any_req_s) begin
            rom_addr  <= win_addr_s;
            rom_rd    <= 1'b1;
            grant_r   <= pick_spr_s;
            streak_r  <= next_streak_s;
            lat_cnt_r <= LAT_LOAD;
            busy      <= 1'b1;
            state_r   <= ST_WAIT;
          end else begin
            // rom_addr deliberately keeps its last value while idle.
            rom_rd  <= 1'b0;
            busy    <= 1'b0;
            state_r <= ST_IDLE;
          end
        end

        ST_WAIT: begin
          // Strobe is only high in the first WAIT cycle.
          rom_rd <= 1'b0;
          if (lat_cnt_r != 3'd0) begin
            lat_cnt_r <= lat_cnt_r - 3'd1;
          end else begin
            if (grant_r == GRANT_SPR) begin
              spr_data <= rom_data;
              spr_ack  <= 1'b1;
            end else begin
              chr_data <= rom_data;
              chr_ack  <= 1'b1;
            end
            state_r <= ST_DONE;
          end
        end

        ST_DONE: begin
          // Requests are ignored here so a held request re-arbitrates in IDLE.
          chr_ack <= 1'b0;
          spr_ack <= 1'b0;
          rom_rd  <= 1'b0;
          busy    <= 1'b0;
          state_r <= ST_IDLE;
        end

        default: begin
          chr_ack <= 1'b0;
          spr_ack <= 1'b0;
          rom_rd  <= 1'b0;
          busy    <= 1'b0;
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

  gfx_rom_arbiter_chk u_chk (
    .clk_sys (clk_sys),
    .reset_n (reset_n),
    .chr_ack (chr_ack),
    .spr_ack (spr_ack),
    .rom_rd  (rom_rd),
    .busy    (busy)
  );

endmodule

// -----------------------------------------------------------------------------
// gfx_rom_arbiter_chk
//
// Protocol properties of the arbiter outputs.
//
// Ports
//   clk_sys, reset_n   clock and asynchronous active-low reset
//   chr_ack, spr_ack   ack pulses
//   rom_rd             ROM read strobe
//   busy               arbiter busy flag
// -----------------------------------------------------------------------------
module gfx_rom_arbiter_chk (
  input logic clk_sys,
  input logic reset_n,
  input logic chr_ack,
  input logic spr_ack,
  input logic rom_rd,
  input logic busy
);

  // The two acks are mutually exclusive.
  ack_onehot: assert property (@(posedge clk_sys) disable iff (!reset_n)
    !(chr_ack && spr_ack));

  // Each strobe and each ack is exactly one cycle long.
  rd_pulse: assert property (@(posedge clk_sys) disable iff (!reset_n)
    rom_rd |=> !rom_rd);

  chr_pulse: assert property (@(posedge clk_sys) disable iff (!reset_n)
    chr_ack |=> !chr_ack);

  spr_pulse: assert property (@(posedge clk_sys) disable iff (!reset_n)
    spr_ack |=> !spr_ack);

  // A strobe only ever happens during an access.
  rd_busy: assert property (@(posedge clk_sys) disable iff (!reset_n)
    rom_rd |-> busy);

endmodule

// File: tb/tb_gfx_rom_arbiter.sv
// -----------------------------------------------------------------------------
// tb_gfx_rom_arbiter
//
// Directed, table-driven bench for gfx_rom_arbiter. A ROM_LAT=2 instance runs
// the vector table and the multi-cycle sequences; a ROM_LAT=1 instance checks
// the short-latency timing. A behavioural ROM drives rom_data only in the
// cycle before the expected sampling edge and garbage otherwise.
// -----------------------------------------------------------------------------
module tb_gfx_rom_arbiter;

  localparam int AW = 12;
  localparam int DW = 16;

  logic clk = 1'b0;
  logic reset_n = 1'b0;

  // 10 time-unit clock
  always #5 clk = ~clk;

  // ROM_LAT=2 instance signals
  logic          chr_req = 1'b0, spr_req = 1'b0;
  logic [AW-1:0] chr_addr = 12'h000, spr_addr = 12'h000;
  logic          chr_ack, spr_ack, rom_rd, busy;
  logic [DW-1:0] chr_data, spr_data, rom_data;
  logic [AW-1:0] rom_addr;

  // ROM_LAT=1 instance signals
  logic          l1_chr_req = 1'b0, l1_spr_req = 1'b0;
  logic [AW-1:0] l1_chr_addr = 12'h000, l1_spr_addr = 12'h000;
  logic          l1_chr_ack, l1_spr_ack, l1_rom_rd, l1_busy;
  logic [DW-1:0] l1_chr_data, l1_spr_data, l1_rom_data;
  logic [AW-1:0] l1_rom_addr;

  gfx_rom_arbiter #(.AW(AW), .DW(DW), .ROM_LAT(2), .STARVE(3)) dut (
    .clk_sys (clk),     .reset_n (reset_n),
    .chr_req (chr_req), .chr_addr(chr_addr), .chr_ack(chr_ack), .chr_data(chr_data),
    .spr_req (spr_req), .spr_addr(spr_addr), .spr_ack(spr_ack), .spr_data(spr_data),
    .rom_addr(rom_addr), .rom_rd (rom_rd),   .rom_data(rom_data), .busy   (busy)
  );

  gfx_rom_arbiter #(.AW(AW), .DW(DW), .ROM_LAT(1), .STARVE(3)) dut1 (
    .clk_sys (clk),        .reset_n (reset_n),
    .chr_req (l1_chr_req), .chr_addr(l1_chr_addr), .chr_ack(l1_chr_ack), .chr_data(l1_chr_data),
    .spr_req (l1_spr_req), .spr_addr(l1_spr_addr), .spr_ack(l1_spr_ack), .spr_data(l1_spr_data),
    .rom_addr(l1_rom_addr), .rom_rd (l1_rom_rd),   .rom_data(l1_rom_data), .busy   (l1_busy)
  );

  // ROM contents: two named words, everything else is {4'hC, addr}.
  function automatic logic [15:0] rom_f(input logic [11:0] a);
    if (a == 12'h1A5) return 16'hBEEF;
    else if (a == 12'hFFF) return 16'h00FF;
    else return {4'hC, a};
  endfunction

  // ROM model: address taken at the edge that sees rom_rd, data valid only
  // for the sampling edge ROM_LAT edges later.
  logic [AW-1:0] pend_addr = 12'h000, l1_pend_addr = 12'h000;
  int pend_cnt = 0, l1_pend_cnt = 0;

  always @(posedge clk) begin
    if (rom_rd === 1'b1) begin
      pend_addr <= rom_addr;
      pend_cnt  <= 2;
    end else if (pend_cnt != 0) begin
      pend_cnt <= pend_cnt - 1;
    end
  end

  always @(posedge clk) begin
    if (l1_rom_rd === 1'b1) begin
      l1_pend_addr <= l1_rom_addr;
      l1_pend_cnt  <= 1;
    end else if (l1_pend_cnt != 0) begin
      l1_pend_cnt <= l1_pend_cnt - 1;
    end
  end

  assign rom_data    = (pend_cnt == 1)    ? rom_f(pend_addr)    : 16'hDEAD;
  assign l1_rom_data = (l1_pend_cnt == 1) ? rom_f(l1_pend_addr) : 16'hDEAD;

  // Count any cycle where both acks of one instance are high.
  int dual_ack = 0;
  always @(negedge clk) begin
    if ((chr_ack === 1'b1 && spr_ack === 1'b1) ||
        (l1_chr_ack === 1'b1 && l1_spr_ack === 1'b1))
      dual_ack <= dual_ack + 1;
  end

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic          c_req;
    logic [AW-1:0] c_addr;
    logic          s_req;
    logic [AW-1:0] s_addr;
    logic          exp_spr;
    logic [AW-1:0] exp_addr;
    logic [DW-1:0] exp_data;
  } vec_t;

  vec_t vecs[11];
  logic [DW-1:0] exp_chr = 16'h0000;
  logic [DW-1:0] exp_spr = 16'h0000;

  // Apply one table record on the ROM_LAT=2 instance and check it.
  task automatic run_vec(input vec_t v, input int idx);
    int got = 0;
    int rd_cnt = 0;
    int wrong = 0;
    logic [AW-1:0] rd_addr = 12'h000;
    string tag;
    tag = $sformatf("vec%0d", idx);
    chr_req = v.c_req; chr_addr = v.c_addr;
    spr_req = v.s_req; spr_addr = v.s_addr;
    for (int k = 1; k <= 12; k++) begin
      tick();
      if (rom_rd === 1'b1) begin
        rd_cnt++;
        rd_addr = rom_addr;
      end
      if ((v.exp_spr ? chr_ack : spr_ack) === 1'b1) wrong++;
      if ((v.exp_spr ? spr_ack : chr_ack) === 1'b1) begin
        got = k;
        break;
      end
    end
    chr_req = 1'b0; spr_req = 1'b0;
    if (v.exp_spr) exp_spr = v.exp_data;
    else exp_chr = v.exp_data;
    check({tag, "_ack_latency"}, got, 4);
    check({tag, "_rd_pulses"}, rd_cnt, 1);
    check({tag, "_rom_addr"}, {20'd0, rd_addr}, {20'd0, v.exp_addr});
    check({tag, "_wrong_ack"}, wrong, 0);
    check({tag, "_chr_data"}, {16'd0, chr_data}, {16'd0, exp_chr});
    check({tag, "_spr_data"}, {16'd0, spr_data}, {16'd0, exp_spr});
    tick();
    check({tag, "_ack_clear"}, {30'd0, chr_ack, spr_ack}, 32'd0);
    check({tag, "_held_data"}, {chr_data, spr_data}, {exp_chr, exp_spr});
    check({tag, "_idle_addr"}, {20'd0, rom_addr}, {20'd0, v.exp_addr});
    check({tag, "_busy_idle"}, {31'd0, busy}, 32'd0);
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int n;
    int acks;
    int bad;
    int order[8];
    int stamp[8];
    int exp_order[8];
    int cyc;

    // Table: c_req c_addr s_req s_addr | winner, rom address, data
    vecs[0]  = '{1'b0, 12'h000, 1'b1, 12'hFFF, 1'b1, 12'hFFF, 16'h00FF}; // sprite only
    vecs[1]  = '{1'b1, 12'h1A5, 1'b0, 12'h000, 1'b0, 12'h1A5, 16'hBEEF}; // char only
    vecs[2]  = '{1'b1, 12'h010, 1'b1, 12'h800, 1'b0, 12'h010, 16'hC010}; // streak 1
    vecs[3]  = '{1'b1, 12'h020, 1'b0, 12'h000, 1'b0, 12'h020, 16'hC020}; // streak 0
    vecs[4]  = '{1'b1, 12'h030, 1'b1, 12'h810, 1'b0, 12'h030, 16'hC030}; // streak 1
    vecs[5]  = '{1'b1, 12'h040, 1'b1, 12'h820, 1'b0, 12'h040, 16'hC040}; // streak 2
    vecs[6]  = '{1'b1, 12'h050, 1'b1, 12'h830, 1'b0, 12'h050, 16'hC050}; // streak 3
    vecs[7]  = '{1'b1, 12'h060, 1'b1, 12'h840, 1'b1, 12'h840, 16'hC840}; // forced sprite
    vecs[8]  = '{1'b1, 12'h070, 1'b1, 12'h850, 1'b0, 12'h070, 16'hC070}; // streak 1
    vecs[9]  = '{1'b0, 12'h000, 1'b1, 12'h860, 1'b1, 12'h860, 16'hC860}; // streak 0
    vecs[10] = '{1'b1, 12'h080, 1'b1, 12'h870, 1'b0, 12'h080, 16'hC080}; // streak 1

    // Reset state
    reset_n = 1'b0;
    tick(); tick(); tick();
    check("rst_outputs", {28'd0, chr_ack, spr_ack, rom_rd, busy}, 32'd0);
    check("rst_data", {chr_data, spr_data}, 32'd0);
    check("rst_rom_addr", {20'd0, rom_addr}, 32'd0);
    check("rst_l1", {l1_chr_data, l1_spr_data}, 32'd0);
    reset_n = 1'b1;
    tick();

    for (int i = 0; i < 11; i++) run_vec(vecs[i], i);

    // Reset one cycle after the strobe: discard the access
    chr_req = 1'b1; chr_addr = 12'h055;
    tick();
    check("mid_rd_seen", {31'd0, rom_rd}, 32'd1);
    tick();
    check("mid_busy_before", {31'd0, busy}, 32'd1);
    reset_n = 1'b0;
    chr_req = 1'b0;
    #1;
    check("mid_busy_async", {31'd0, busy}, 32'd0);
    check("mid_data_async", {chr_data, spr_data}, 32'd0);
    check("mid_addr_async", {20'd0, rom_addr}, 32'd0);
    exp_chr = 16'h0000; exp_spr = 16'h0000;
    tick(); tick();
    reset_n = 1'b1;
    acks = 0; bad = 0;
    for (int k = 0; k < 10; k++) begin
      tick();
      if (chr_ack === 1'b1 || spr_ack === 1'b1) acks++;
      if (busy !== 1'b0 || rom_rd !== 1'b0) bad++;
    end
    check("mid_no_ack", acks, 0);
    check("mid_stays_idle", bad, 0);
    check("mid_chr_data", {16'd0, chr_data}, 32'd0);

    // Continuous contention from streak 0: C,C,C,S,C,C,C,S every 5 cycles
    exp_order = '{0, 0, 0, 1, 0, 0, 0, 1};
    chr_req = 1'b1; chr_addr = 12'h111;
    spr_req = 1'b1; spr_addr = 12'h222;
    n = 0; bad = 0;
    for (int k = 1; k <= 60 && n < 8; k++) begin
      tick();
      if (chr_ack === 1'b1) begin
        order[n] = 0; stamp[n] = k; n++;
        if (chr_data !== 16'hC111) bad++;
      end else if (spr_ack === 1'b1) begin
        order[n] = 1; stamp[n] = k; n++;
        if (spr_data !== 16'hC222) bad++;
      end
    end
    chr_req = 1'b0; spr_req = 1'b0;
    check("starve_ack_count", n, 8);
    check("starve_data", bad, 0);
    check("starve_first_latency", stamp[0], 4);
    for (int j = 0; j < 8; j++) begin
      if (j < n) begin
        check($sformatf("starve_order%0d", j), order[j], exp_order[j]);
        if (j > 0) check($sformatf("starve_gap%0d", j), stamp[j] - stamp[j-1], 5);
      end
    end
    tick(); tick(); tick();

    // Address change after the grant is ignored
    chr_req = 1'b1; chr_addr = 12'h010;
    tick();
    chr_addr = 12'h020;
    check("addr_rd_first", {19'd0, rom_rd, rom_addr}, {19'd0, 1'b1, 12'h010});
    n = 0; bad = 0;
    for (int k = 2; k <= 12; k++) begin
      tick();
      if (rom_addr !== 12'h010) bad++;
      if (chr_ack === 1'b1) begin
        n = k;
        break;
      end
    end
    chr_req = 1'b0;
    check("addr_latency", n, 4);
    check("addr_rom_addr_held", bad, 0);
    check("addr_chr_data", {16'd0, chr_data}, 32'h0000C010);
    tick(); tick();

    // ROM_LAT=1 instance: single read, ack in the cycle after E2
    l1_chr_req = 1'b1; l1_chr_addr = 12'h1A5;
    n = 0; bad = 0;
    for (int k = 1; k <= 10; k++) begin
      tick();
      if (l1_spr_ack === 1'b1) bad++;
      if (l1_chr_ack === 1'b1) begin
        n = k;
        break;
      end
    end
    l1_chr_req = 1'b0;
    check("l1_latency", n, 3);
    check("l1_chr_data", {16'd0, l1_chr_data}, 32'h0000BEEF);
    check("l1_no_spr_ack", bad, 0);
    tick(); tick();

    // ROM_LAT=1 back-to-back: one completion every 4 cycles
    l1_chr_req = 1'b1; l1_chr_addr = 12'h333;
    n = 0;
    cyc = 0;
    for (int k = 1; k <= 30 && n < 3; k++) begin
      tick();
      if (l1_chr_ack === 1'b1) begin
        stamp[n] = k; n++;
      end
    end
    l1_chr_req = 1'b0;
    check("l1_b2b_count", n, 3);
    check("l1_b2b_first", stamp[0], 3);
    check("l1_b2b_gap1", stamp[1] - stamp[0], 4);
    check("l1_b2b_gap2", stamp[2] - stamp[1], 4);
    check("l1_b2b_data", {16'd0, l1_chr_data}, 32'h0000C333);
    tick(); tick();

    check("no_dual_ack", dual_ack, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
